// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
// Holds the RV32I load/store size codes and the responder FSM state encoding.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_if.sv
// Load/store request and response handshake between the memory stage and the data RAM.
interface dmem_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering shared by loads and stores: extracts and extends load data,
// and produces the byte enables plus lane-replicated write data for stores.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] ram_word,
  input  logic [31:0] st_data,
  output logic [31:0] ld_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    case (addr_lo)
      2'd0:    ld_byte = ram_word[7:0];
      2'd1:    ld_byte = ram_word[15:8];
      2'd2:    ld_byte = ram_word[23:16];
      default: ld_byte = ram_word[31:24];
    endcase
    ld_half = addr_lo[1] ? ram_word[31:16] : ram_word[15:0];

    case (funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'd0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'd0, ld_half};
      default: ld_data = ram_word;
    endcase
  end

  // Store data is replicated across lanes so the byte enable alone picks the target.
  always_comb begin
    case (funct3)
      F3_B: begin
        st_be    = 4'b0001 << addr_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      F3_H: begin
        st_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = st_data;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, programmable wait states,
// sized little-endian loads/stores into a word-organised RAM with error reporting.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  dmem_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        busy_q, busy_d;

  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic [31:0]      ram_word;
  logic [31:0]      ld_data;
  logic [31:0]      st_wdata;
  logic [3:0]       st_be;
  logic             mem_we;
  logic             acc_err;

  function automatic logic req_error(input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr);
    logic bad;
    if (we) bad = !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
    else    bad = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    if ((f3 == F3_H || f3 == F3_HU) && addr[0]) bad = 1'b1;
    if (f3 == F3_W && addr[1:0] != 2'b00)       bad = 1'b1;
    if ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS)) bad = 1'b1;
    return bad;
  endfunction

  assign idx      = addr_q[IDX_W+1:2];
  assign ram_word = mem[idx];
  assign acc_err  = req_error(we_q, f3_q, addr_q);

  dmem_lane_align u_align (
    .addr_lo  (addr_q[1:0]),
    .funct3   (f3_q),
    .ram_word (ram_word),
    .st_data  (wdata_q),
    .ld_data  (ld_data),
    .st_be    (st_be),
    .st_wdata (st_wdata)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    busy_d       = busy_q;
    we_d         = we_q;
    f3_d         = f3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_we       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          f3_d    = bus.req_funct3;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = 4'(WAIT_CYCLES);
          busy_d  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = acc_err;
          resp_rdata_d = 32'd0;
          if (!acc_err) begin
            if (we_q) mem_we = 1'b1;
            else      resp_rdata_d = ld_data;
          end
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = 32'd0;
          busy_d       = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      busy_q       <= busy_d;
    end
  end

  // Captured request fields are only consumed in ACCESS, so they need no reset.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    f3_q    <= f3_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we && st_be[i]) mem[idx][8*i +: 8] <= st_wdata[8*i +: 8];
    end
  end

  assign bus.req_ready  = (state_q == IDLE) && !rst;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized load/store traffic
// compared against a byte-addressed reference memory.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int WAIT  = 2;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [7:0] ref_mem [DEPTH*4];

  dmem_if bus ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: byte-granular memory, access size from funct3, little-endian assembly.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] d, output logic e);
    int  nb;
    bit  legal;
    nb    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    e     = !legal || (addr % nb != 0) || (addr / 4 >= DEPTH);
    d     = 32'd0;
    if (!e) begin
      if (we) begin
        for (int i = 0; i < nb; i++) ref_mem[int'(addr) + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < nb; i++) d = d | (32'(ref_mem[int'(addr) + i]) << (8*i));
        if (!f3[2] && nb < 4 && d[8*nb-1]) d = d | (32'hFFFF_FFFF << (8*nb));
      end
    end
  endtask

  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int bp, input string tag,
                         output logic [31:0] got_d, output logic got_e);
    logic [31:0] exp_d;
    logic        exp_e;
    int          guard;
    int          lat;
    model(we, f3, addr, wd, exp_d, exp_e);
    bus.resp_ready = (bp == 0);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    check({tag, "_accept"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    // Junk on the request side while busy must not disturb the transaction.
    bus.req_valid  = 1'($urandom);
    bus.req_we     = 1'($urandom);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    lat = 0;
    while (!bus.resp_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    bus.req_valid = 1'b0;
    check({tag, "_lat"}, 32'(lat), 32'(WAIT + 1));
    check({tag, "_rdata"}, bus.resp_rdata, exp_d);
    check({tag, "_err"}, 32'(bus.resp_err), 32'(exp_e));
    got_d = bus.resp_rdata;
    got_e = bus.resp_err;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(bus.resp_valid), 32'd1);
      check({tag, "_hold_rdata"}, bus.resp_rdata, exp_d);
      check({tag, "_hold_err"}, 32'(bus.resp_err), 32'(exp_e));
      check({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_done_valid"}, 32'(bus.resp_valid), 32'd0);
    check({tag, "_done_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, "_done_busy"}, 32'(bus.busy), 32'd0);
  endtask

  logic [31:0] d;
  logic        e;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.resp_ready = 1'b1;

    @(posedge clk); #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_rdata", bus.resp_rdata, 32'd0);
    check("rst_err", 32'(bus.resp_err), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(bus.req_ready), 32'd1);

    run_txn(1'b1, F3_W, 32'h10, 32'hDEADBEEF, 0, "sw10", d, e);
    check("sw10_err_c", 32'(e), 32'd0);
    run_txn(1'b0, F3_W, 32'h10, 32'h0, 0, "lw10", d, e);
    check("lw10_c", d, 32'hDEADBEEF);
    run_txn(1'b0, F3_B, 32'h13, 32'h0, 0, "lb13", d, e);
    check("lb13_c", d, 32'hFFFFFFDE);
    run_txn(1'b0, F3_BU, 32'h13, 32'h0, 0, "lbu13", d, e);
    check("lbu13_c", d, 32'h000000DE);
    run_txn(1'b0, F3_H, 32'h12, 32'h0, 0, "lh12", d, e);
    check("lh12_c", d, 32'hFFFFDEAD);
    run_txn(1'b0, F3_HU, 32'h10, 32'h0, 0, "lhu10", d, e);
    check("lhu10_c", d, 32'h0000BEEF);
    run_txn(1'b1, F3_B, 32'h11, 32'h55, 0, "sb11", d, e);
    run_txn(1'b0, F3_W, 32'h10, 32'h0, 0, "lw10b", d, e);
    check("lw10b_c", d, 32'hDEAD55EF);
    run_txn(1'b0, F3_W, 32'h12, 32'h0, 0, "lw12", d, e);
    check("lw12_err_c", 32'(e), 32'd1);
    check("lw12_rdata_c", d, 32'd0);
    run_txn(1'b1, F3_H, 32'h11, 32'hAAAA, 0, "sh11", d, e);
    check("sh11_err_c", 32'(e), 32'd1);
    run_txn(1'b0, F3_W, 32'h10, 32'h0, 0, "lw10c", d, e);
    check("lw10c_c", d, 32'hDEAD55EF);
    run_txn(1'b0, 3'd3, 32'h10, 32'h0, 0, "ld_f3_3", d, e);
    check("ld_f3_3_c", 32'(e), 32'd1);
    run_txn(1'b0, F3_W, 32'h1000, 32'h0, 0, "lw_oor", d, e);
    check("lw_oor_c", 32'(e), 32'd1);
    run_txn(1'b0, F3_W, 32'h10, 32'h0, 10, "bp10", d, e);

    // Reset landing in ACCESS must drop the store before its commit edge.
    run_txn(1'b1, F3_W, 32'h20, 32'hCAFEF00D, 0, "sw20", d, e);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'h12345678;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("mid_busy", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(bus.resp_valid), 32'd0);
    check("mid_rst_rdata", bus.resp_rdata, 32'd0);
    check("mid_rst_err", 32'(bus.resp_err), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_idle", 32'(bus.req_ready), 32'd1);
    run_txn(1'b0, F3_W, 32'h20, 32'h0, 0, "lw20", d, e);
    check("lw20_c", d, 32'hCAFEF00D);

    for (int w = 0; w < 64; w++) run_txn(1'b1, F3_W, 32'(w * 4), $urandom, 0, "fill", d, e);

    for (int n = 0; n < 200; n++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      int          r;
      int          bp;
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we) f3 = 3'($urandom_range(0, 2));
      else begin
        r  = $urandom_range(0, 4);
        f3 = (r < 3) ? 3'(r) : 3'(r + 1);
      end
      r = $urandom_range(0, 15);
      if (r == 0)      addr = $urandom | 32'h0001_0000;
      else if (r == 1) addr = 32'h1000 + ($urandom & 32'hFFF);
      else             addr = 32'($urandom_range(0, 255));
      bp = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      run_txn(we, f3, addr, $urandom, bp, "rnd", d, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
